// File: rtl/dds_sample_gen_pkg.sv
// rtl/dds_sample_gen_pkg.sv - shared state encoding, widths and triangle fold for the DDS sample generator
// Contents: dds_state_t (IDLE/RUN/HOLD/FLUSH), datapath widths, overrun saturation value, triangle().
package dds_sample_gen_pkg;

    localparam int PHASE_W  = 24;
    localparam int SAMPLE_W = 14;
    localparam int OVR_W    = 8;
    localparam int MODE_W   = 3;

    localparam logic [OVR_W-1:0] OVR_SAT = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } dds_state_t;

    // Upper half of the phase circle is mirrored so the output ramps up, then back down.
    function automatic logic [SAMPLE_W-1:0] triangle(input logic [PHASE_W-1:0] p);
        logic [SAMPLE_W-1:0] mag;
        mag = p[PHASE_W-2 -: SAMPLE_W];
        return p[PHASE_W-1] ? ~mag : mag;
    endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// rtl/dds_phase_acc.sv - 24-bit phase accumulator with latched frequency word
// Ports: clk/rst_n (async active-low), clear (phase<=0), load (latch freq_word),
//        advance (phase<=phase+word), freq_word in, phase_next out (phase+word, combinational).
module dds_phase_acc
    import dds_sample_gen_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic               advance,
    input  logic [PHASE_W-1:0] freq_word,
    output logic [PHASE_W-1:0] phase_next
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] word_q;

    // Natural modulo-2^24 wrap; no saturation.
    assign phase_next = phase_q + word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            word_q  <= '0;
        end else begin
            if (load) begin
                word_q <= freq_word;
            end
            if (clear) begin
                phase_q <= '0;
            end else if (advance) begin
                phase_q <= phase_next;
            end
        end
    end

endmodule

// File: rtl/dds_sample_gen.sv
// rtl/dds_sample_gen.sv - DDS triangle sample generator with one-deep output hold and overrun count
// Ports: Fg_CLK, Fg_RESETn (async active-low), DDSEnable (sample strobe), DDSReady (start pulse),
//        DDSMode (rate mode; change flushes), iFreqWord (phase increment), iSampleReady (accept),
//        oSample/oSampleValid (held sample), oOverrun (saturating drop count), oState (FSM debug).
module dds_sample_gen
    import dds_sample_gen_pkg::*;
(
    input  logic                Fg_CLK,
    input  logic                Fg_RESETn,
    input  logic                DDSEnable,
    input  logic                DDSReady,
    input  logic [MODE_W-1:0]   DDSMode,
    input  logic [PHASE_W-1:0]  iFreqWord,
    input  logic                iSampleReady,
    output logic [SAMPLE_W-1:0] oSample,
    output logic                oSampleValid,
    output logic [OVR_W-1:0]    oOverrun,
    output logic [1:0]          oState
);

    dds_state_t          state_q;
    dds_state_t          state_d;
    logic [MODE_W-1:0]   mode_q;
    logic [SAMPLE_W-1:0] sample_q;
    logic                valid_q;
    logic [OVR_W-1:0]    ovr_q;
    logic [PHASE_W-1:0]  phase_next;

    logic mode_chg;
    logic accept;
    logic acc_clear;
    logic acc_load;
    logic acc_advance;
    logic smp_load;
    logic smp_drop;
    logic ovr_inc;

    assign mode_chg = (DDSMode != mode_q);
    assign accept   = valid_q & iSampleReady;

    dds_phase_acc u_acc (
        .clk        (Fg_CLK),
        .rst_n      (Fg_RESETn),
        .clear      (acc_clear),
        .load       (acc_load),
        .advance    (acc_advance),
        .freq_word  (iFreqWord),
        .phase_next (phase_next)
    );

    always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
        if (!Fg_RESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A mode change outranks any strobe or acceptance on the same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (DDSReady) state_d = ST_RUN;
            ST_RUN: begin
                if (mode_chg)       state_d = ST_FLUSH;
                else if (DDSEnable) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (mode_chg)                    state_d = ST_FLUSH;
                else if (accept && !DDSEnable)   state_d = ST_RUN;
            end
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Flush work (clear phase, relatch word, drop sample) happens on the edge that
    // enters FLUSH, so the FLUSH cycle itself is a dead cycle that ignores strobes.
    always_comb begin
        acc_clear   = 1'b0;
        acc_load    = 1'b0;
        acc_advance = 1'b0;
        smp_load    = 1'b0;
        smp_drop    = 1'b0;
        ovr_inc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (DDSReady) begin
                    acc_clear = 1'b1;
                    acc_load  = 1'b1;
                end
            end
            ST_RUN: begin
                if (mode_chg) begin
                    acc_clear = 1'b1;
                    acc_load  = 1'b1;
                    smp_drop  = 1'b1;
                end else if (DDSEnable) begin
                    acc_advance = 1'b1;
                    smp_load    = 1'b1;
                end
            end
            ST_HOLD: begin
                if (mode_chg) begin
                    acc_clear = 1'b1;
                    acc_load  = 1'b1;
                    smp_drop  = 1'b1;
                end else if (DDSEnable) begin
                    // The phase keeps moving even when the new sample has nowhere to go.
                    acc_advance = 1'b1;
                    smp_load    = accept;
                    ovr_inc     = !accept;
                end else if (accept) begin
                    smp_drop = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
        if (!Fg_RESETn) begin
            mode_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= '0;
        end else begin
            mode_q <= DDSMode;
            if (smp_load) begin
                sample_q <= triangle(phase_next);
                valid_q  <= 1'b1;
            end else if (smp_drop) begin
                valid_q <= 1'b0;
            end
            if (ovr_inc && (ovr_q != OVR_SAT)) begin
                ovr_q <= ovr_q + 1'b1;
            end
        end
    end

    assign oSample      = sample_q;
    assign oSampleValid = valid_q;
    assign oOverrun     = ovr_q;
    assign oState       = state_q;

endmodule

// File: tb/tb_dds_sample_gen.sv
// tb/tb_dds_sample_gen.sv - self-checking bench for dds_sample_gen against a behavioural model
module tb_dds_sample_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        rdy;
    logic [2:0]  mode;
    logic [23:0] fw;
    logic        sready;
    logic [13:0] o_sample;
    logic        o_valid;
    logic [7:0]  o_ovr;
    logic [1:0]  o_state;

    int errors = 0;
    int checks = 0;

    // Behavioural reference state
    int unsigned m_state;
    int unsigned m_phase;
    int unsigned m_inc;
    int unsigned m_mode;
    int unsigned m_sample;
    int unsigned m_valid;
    int unsigned m_ovr;

    always #5 clk = ~clk;

    dds_sample_gen dut (
        .Fg_CLK       (clk),
        .Fg_RESETn    (rst_n),
        .DDSEnable    (ena),
        .DDSReady     (rdy),
        .DDSMode      (mode),
        .iFreqWord    (fw),
        .iSampleReady (sready),
        .oSample      (o_sample),
        .oSampleValid (o_valid),
        .oOverrun     (o_ovr),
        .oState       (o_state)
    );

    function automatic int unsigned tri_ref(input int unsigned p);
        if (p < 32'h80_0000) return p / 512;
        return 16383 - ((p - 32'h80_0000) / 512);
    endfunction

    task automatic model_reset();
        m_state = 0; m_phase = 0; m_inc = 0; m_mode = 0;
        m_sample = 0; m_valid = 0; m_ovr = 0;
    endtask

    task automatic model_flush();
        m_phase = 0;
        m_inc   = fw;
        m_valid = 0;
        m_state = 3;
    endtask

    task automatic model_step();
        bit acc;
        bit chg;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = (m_valid == 1) && sready;
        chg = (mode != m_mode);
        case (m_state)
            0: if (rdy) begin m_state = 1; m_inc = fw; m_phase = 0; end
            1: begin
                if (chg) model_flush();
                else if (ena) begin
                    m_phase  = (m_phase + m_inc) % 32'h100_0000;
                    m_sample = tri_ref(m_phase);
                    m_valid  = 1;
                    m_state  = 2;
                end
            end
            2: begin
                if (chg) model_flush();
                else if (ena) begin
                    m_phase = (m_phase + m_inc) % 32'h100_0000;
                    if (acc) m_sample = tri_ref(m_phase);
                    else if (m_ovr < 255) m_ovr = m_ovr + 1;
                end else if (acc) begin
                    m_valid = 0;
                    m_state = 1;
                end
            end
            default: m_state = 1;
        endcase
        m_mode = mode;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sample"}, 32'(o_sample), m_sample);
        chk({tag, ".valid"},  32'(o_valid),  m_valid);
        chk({tag, ".ovr"},    32'(o_ovr),    m_ovr);
        chk({tag, ".state"},  32'(o_state),  m_state);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; rdy = 1'b0; mode = 3'd0; fw = 24'h0; sready = 1'b0;
        model_reset();
        step("reset");
        step("reset2");
        rst_n = 1'b1;

        // Start: first strobe yields 128 one cycle later
        fw = 24'h01_0000; rdy = 1'b1;
        step("start_ready");
        rdy = 1'b0; fw = 24'h0A_BCDE;
        ena = 1'b1;
        step("start_strobe");
        ena = 1'b0;
        chk("start_sample", 32'(o_sample), 32'd128);
        chk("start_valid",  32'(o_valid),  32'd1);

        // Ramp to phase 0x800000 with accept+strobe every cycle, then fold
        sready = 1'b1; ena = 1'b1;
        repeat (127) step("ramp");
        chk("fold_peak", 32'(o_sample), 32'h3FFF);
        step("fold");
        chk("fold_sample", 32'(o_sample), 32'h3F7F);
        ena = 1'b0;
        step("drain");
        chk("drain_state", 32'(o_state), 32'd1);

        // Backpressure: three strobes, first sample held, two overruns
        sready = 1'b0; ena = 1'b1;
        repeat (3) step("bp_strobe");
        ena = 1'b0;
        chk("bp_ovr",    32'(o_ovr),    32'd2);
        chk("bp_sample", 32'(o_sample), 32'(tri_ref(32'h82_0000)));
        sready = 1'b1;
        step("bp_accept");
        chk("bp_valid", 32'(o_valid), 32'd0);
        chk("bp_state", 32'(o_state), 32'd1);

        // Simultaneous accept and strobe, then overrun saturation
        sready = 1'b0; ena = 1'b1;
        step("sim_load");
        sready = 1'b1;
        step("sim_both");
        chk("sim_ovr",   32'(o_ovr),   32'd2);
        chk("sim_valid", 32'(o_valid), 32'd1);
        sready = 1'b0;
        repeat (300) step("sat");
        chk("sat_ovr", 32'(o_ovr), 32'd255);
        ena = 1'b0;

        // Mode change 0->1 in HOLD, then 1->2 with a strobe and a new word
        mode = 3'd1;
        step("mode1_flush");
        step("mode1_run");
        ena = 1'b1;
        step("mode1_strobe");
        mode = 3'd2; fw = 24'h12_3456;
        step("mode2_flush");
        chk("mode2_state", 32'(o_state), 32'd3);
        chk("mode2_valid", 32'(o_valid), 32'd0);
        step("mode2_ignored");
        chk("mode2_run", 32'(o_state), 32'd1);
        step("mode2_first");
        chk("mode2_sample", 32'(o_sample), 32'h91A);
        ena = 1'b0;

        // Randomized traffic; iFreqWord churns between latch points
        for (int i = 0; i < 400; i++) begin
            ena    = ($urandom_range(0, 2) == 0);
            sready = $urandom_range(0, 1);
            rdy    = $urandom_range(0, 1);
            fw     = 24'($urandom);
            if ($urandom_range(0, 39) == 0) mode = 3'($urandom_range(0, 3));
            step("rand");
        end
        ena = 1'b0; rdy = 1'b0; mode = 3'd0;

        // Zero increment gives a constant zero sample
        rst_n = 1'b0;
        step("z_reset");
        rst_n = 1'b1; fw = 24'h0; rdy = 1'b1;
        step("z_ready");
        rdy = 1'b0; sready = 1'b1; fw = 24'h55_5555;
        for (int i = 0; i < 5; i++) begin
            ena = 1'b1;
            step("z_strobe");
            chk("z_sample", 32'(o_sample), 32'd0);
        end
        ena = 1'b0;

        // Mode change in IDLE is tracked, no flush
        rst_n = 1'b0;
        step("i_reset");
        rst_n = 1'b1; mode = 3'd3;
        step("i_mode");
        chk("i_state", 32'(o_state), 32'd0);
        mode = 3'd1;
        step("i_mode2");

        // Reset asserted mid-HOLD clears everything without a clock edge
        rdy = 1'b1; fw = 24'h04_0000;
        step("r_ready");
        rdy = 1'b0; ena = 1'b1; sready = 1'b0;
        step("r_hold");
        ena = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        m_mode = 0;
        check_all("r_async");
        #1 rst_n = 1'b1;
        mode = 3'd0; ena = 1'b1; sready = 1'b1;
        repeat (3) step("r_ignored");
        chk("r_idle", 32'(o_state), 32'd0);
        ena = 1'b0; rdy = 1'b1;
        step("r_ready2");
        rdy = 1'b0; ena = 1'b1;
        step("r_strobe");
        chk("r_sample", 32'(o_sample), 32'd512);
        ena = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
